// File: rtl/stream_gather_arb.sv
// N-to-1 packet-aware gather mux: round-robin arbitration per packet, lock held
// until the granted channel's last beat, single registered output stage.
module stream_gather_arb #(
    parameter int NUM_IN     = 15,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_IN-1:0]     in_valid,
    input  logic [DATA_WIDTH-1:0] in_data [NUM_IN-1:0],
    input  logic [NUM_IN-1:0]     in_last,
    output logic [NUM_IN-1:0]     in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [SEL_WIDTH-1:0]  out_sel,
    input  logic                  out_ready
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic [SEL_WIDTH:0]   NUM_IN_EXT = (SEL_WIDTH+1)'(NUM_IN);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX   = SEL_WIDTH'(NUM_IN - 1);

    state_t                state_q, state_d;
    logic [SEL_WIDTH-1:0]  grant_q, grant_d;
    logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;

    logic                  can_load;
    logic                  sel_found;
    logic [SEL_WIDTH-1:0]  sel_idx;
    logic [SEL_WIDTH:0]    cand;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;

    function automatic logic [SEL_WIDTH-1:0] next_idx(input logic [SEL_WIDTH-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + SEL_WIDTH'(1);
    endfunction

    assign can_load = !out_valid_q || out_ready;

    // Scan only depends on valids and state, keeping in_data/in_last off the in_ready path.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        if (state_q == LOCKED) begin
            sel_idx   = grant_q;
            sel_found = in_valid[grant_q];
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                cand = {1'b0, rr_ptr_q} + (SEL_WIDTH+1)'(k);
                if (cand >= NUM_IN_EXT) begin
                    cand = cand - NUM_IN_EXT;
                end
                if (!sel_found && in_valid[cand[SEL_WIDTH-1:0]]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand[SEL_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && can_load && sel_found) begin
            in_ready[sel_idx] = 1'b1;
        end
    end

    assign accept   = |in_ready;
    assign sel_data = in_data[sel_idx];
    assign sel_last = in_last[sel_idx];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_sel_d   = sel_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_last) begin
                        rr_ptr_d = next_idx(sel_idx);
                    end else begin
                        state_d = LOCKED;
                        grant_d = sel_idx;
                    end
                end
            end
            LOCKED: begin
                if (accept && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_idx(grant_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_gather_arb.sv
// Directed bench for stream_gather_arb: per-channel source queues drive the inputs,
// a negedge monitor pops the expected-beat scoreboard whenever an output beat transfers.
module tb_stream_gather_arb;

    localparam int NUM_IN = 15;
    localparam int DW     = 8;
    localparam int SW     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_IN-1:0] in_valid;
    logic [DW-1:0]     in_data [NUM_IN-1:0];
    logic [NUM_IN-1:0] in_last;
    logic [NUM_IN-1:0] in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [SW-1:0]     out_sel;
    logic              out_ready;

    logic [NUM_IN-1:0] drv_valid = '0;
    logic [NUM_IN-1:0] pause = '0;
    logic [NUM_IN-1:0] fire;
    logic [8:0]        src_q [NUM_IN][$];
    logic [12:0]       exp_q [$];

    int total = 0;
    int bad = 0;
    int out_count = 0;

    stream_gather_arb #(
        .NUM_IN(NUM_IN),
        .DATA_WIDTH(DW),
        .SEL_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_last(out_last),
        .out_sel(out_sel),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    assign in_valid = drv_valid & ~pause;

    always @(negedge clk) begin
        fire = in_valid & in_ready & {NUM_IN{rst_n}};
    end

    // Upstream model: retire the head beat once it was accepted, then present the next one.
    always @(posedge clk) begin
        logic [8:0] head;
        #1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (fire[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
            end
            if (src_q[i].size() > 0) begin
                head         = src_q[i][0];
                drv_valid[i] = 1'b1;
                in_data[i]   = head[7:0];
                in_last[i]   = head[8];
            end else begin
                drv_valid[i] = 1'b0;
                in_data[i]   = 8'hEE;
                in_last[i]   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [12:0] exp_beat;
        if (rst_n && out_valid && out_ready) begin
            out_count++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_beat got sel=%0d last=%0b data=%02h expected none",
                         out_sel, out_last, out_data);
            end else begin
                exp_beat = exp_q.pop_front();
                if ({out_sel, out_last, out_data} !== exp_beat) begin
                    bad++;
                    $display("[TB] FAIL beat_%0d got sel=%0d last=%0b data=%02h expected sel=%0d last=%0b data=%02h",
                             out_count, out_sel, out_last, out_data,
                             exp_beat[12:9], exp_beat[8], exp_beat[7:0]);
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int ch, input logic [7:0] first_data, input int beats);
        for (int b = 0; b < beats; b++) begin
            src_q[ch].push_back({(b == beats - 1) ? 1'b1 : 1'b0, first_data + 8'(b)});
        end
    endtask

    task automatic expect_beat(input int ch, input logic [7:0] data, input logic last);
        exp_q.push_back({4'(ch), last, data});
    endtask

    task automatic expect_packet(input int ch, input logic [7:0] first_data, input int beats);
        for (int b = 0; b < beats; b++) begin
            expect_beat(ch, first_data + 8'(b), (b == beats - 1) ? 1'b1 : 1'b0);
        end
    endtask

    function automatic int src_pending();
        int n = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            n += src_q[i].size();
        end
        return n;
    endfunction

    task automatic wait_drain(input string name);
        int cycles = 0;
        while ((exp_q.size() != 0 || src_pending() != 0) && cycles < 300) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        check_output({name, "_drain_exp"}, 32'(exp_q.size()), 32'd0);
        check_output({name, "_drain_src"}, 32'(src_pending()), 32'd0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic wait_src_size(input int ch, input int n, input string name);
        int cycles = 0;
        while (src_q[ch].size() != n && cycles < 100) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        check_output({name, "_src_wait"}, 32'(src_q[ch].size()), 32'(n));
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        out_ready = 1'b1;

        // Reset with every channel requesting a single-beat packet
        for (int i = 0; i < NUM_IN; i++) begin
            apply_stimulus(i, 8'hC0 + 8'(i), 1);
            expect_packet(i, 8'hC0 + 8'(i), 1);
        end
        repeat (3) @(posedge clk);
        #2;
        check_output("rst_in_valid_all", 32'(in_valid), 32'h7FFF);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_out_data", 32'(out_data), 32'd0);
        check_output("rst_out_sel", 32'(out_sel), 32'd0);
        check_output("rst_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        wait_drain("all_channels");

        // Simultaneous single-beat packets, then wrap check of rr_ptr
        apply_stimulus(2, 8'hA2, 1);
        apply_stimulus(5, 8'hA5, 1);
        apply_stimulus(14, 8'hAE, 1);
        expect_packet(2, 8'hA2, 1);
        expect_packet(5, 8'hA5, 1);
        expect_packet(14, 8'hAE, 1);
        wait_drain("rr_2_5_14");
        apply_stimulus(1, 8'hB1, 1);
        apply_stimulus(0, 8'hB0, 1);
        expect_packet(0, 8'hB0, 1);
        expect_packet(1, 8'hB1, 1);
        wait_drain("rr_wrap");

        // Multi-beat packet keeps the lock while another channel waits
        apply_stimulus(3, 8'h10, 4);
        apply_stimulus(1, 8'h21, 1);
        expect_packet(3, 8'h10, 4);
        expect_packet(1, 8'h21, 1);
        wait_drain("lock_ch3");

        // Back-pressure mid-packet
        base = out_count;
        apply_stimulus(6, 8'h60, 4);
        expect_packet(6, 8'h60, 4);
        for (int c = 0; c < 100 && out_count != base + 2; c++) begin
            @(posedge clk);
            #2;
        end
        check_output("bp_start_count", 32'(out_count - base), 32'd2);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_output("bp_out_data", 32'(out_data), 32'h62);
            check_output("bp_out_valid", 32'(out_valid), 32'd1);
            check_output("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain("backpressure");
        check_output("bp_beats_out", 32'(out_count - base), 32'd4);

        // Gap on the locked channel while channel 8 requests
        apply_stimulus(7, 8'h70, 3);
        apply_stimulus(8, 8'h81, 1);
        expect_packet(7, 8'h70, 3);
        expect_packet(8, 8'h81, 1);
        wait_src_size(7, 2, "gap");
        pause[7] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("gap_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #2;
        pause[7] = 1'b0;
        wait_drain("locked_gap");

        // Reset during the second beat of a 3-beat packet
        apply_stimulus(11, 8'hB0, 3);
        expect_beat(11, 8'hB0, 1'b0);
        wait_src_size(11, 1, "midrst");
        rst_n = 1'b0;
        #1;
        check_output("midrst_out_valid", 32'(out_valid), 32'd0);
        check_output("midrst_in_ready", 32'(in_ready), 32'd0);
        check_output("midrst_out_sel", 32'(out_sel), 32'd0);
        check_output("midrst_out_data", 32'(out_data), 32'd0);
        check_output("midrst_exp_left", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < NUM_IN; i++) begin
            src_q[i].delete();
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        apply_stimulus(9, 8'h99, 1);
        expect_packet(9, 8'h99, 1);
        wait_drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got time=%0t expected finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
